velocity_selector_arbiter: RTL and testbench

- Round-robin scheduler that shares one velocity-selector datapath (rect→polar→rect rotation unit, start/done style) among NUM_REQ requesters.
- Latches the winning requester's x/y operands and holds the datapath active until done.
- Returns the rotated x/y result to the winner with a one-cycle ack/valid.
- Sits between the per-requester velocity update logic and the single shared velocity selector instance.

---
 rtl/velocity_selector_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_velocity_selector_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_selector_arbiter.sv
// -----------------------------------------------------------------------------
// velocity_selector_arbiter
//
// Round-robin scheduler that shares one velocity-selector datapath
// (rect->polar->rect rotation unit, start/done handshake) among NUM_REQ
// requesters. The winning requester's x/y operands are latched at grant and
// held on dp_x/dp_y while dp_active is high. When the datapath reports done,
// the rotated result is registered and handed back to the winner with a
// one-cycle ack / res_valid strobe.
//
// Optional feature (compile-time macro VS_ARB_TIMEOUT_EN):
//   A RUN-cycle counter aborts a job that has not seen dp_done after TIMEOUT
//   cycles. The job then completes with res_x = res_y = 0 and res_err = 1.
//   With the macro undefined there is no counter, RUN waits indefinitely and
//   res_err is tied to 0.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req        in   [NUM_REQ]        per-requester request level
//   x_in/y_in  in   [NUM_REQ*WIDTH]  packed operands, requester i at [i*WIDTH +: WIDTH]
//   ack        out  [NUM_REQ]        one-hot, one-cycle completion pulse
//   dp_active  out                   enable to the shared datapath
//   dp_x/dp_y  out  [WIDTH]          latched operands to the datapath
//   dp_done    in                    datapath completion pulse
//   dp_x_rot/dp_y_rot in [WIDTH]     datapath results
//   res_x/res_y out [WIDTH]          registered results
//   res_id     out  [ID_W]           index of the served requester
//   res_valid  out                   one-cycle result strobe
//   res_err    out                   job aborted by timeout (qualify with res_valid)
//   busy       out                   high while a job is in RUN or RESP
// -----------------------------------------------------------------------------
module velocity_selector_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] x_in,
  input  logic [NUM_REQ*WIDTH-1:0] y_in,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     dp_active,
  output logic [WIDTH-1:0]         dp_x,
  output logic [WIDTH-1:0]         dp_y,
  input  logic                     dp_done,
  input  logic [WIDTH-1:0]         dp_x_rot,
  input  logic [WIDTH-1:0]         dp_y_rot,
  output logic [WIDTH-1:0]         res_x,
  output logic [WIDTH-1:0]         res_y,
  output logic [ID_W-1:0]          res_id,
  output logic                     res_valid,
  output logic                     res_err,
  output logic                     busy
);

  // Elaboration-time parameter sanity checks.
  if (ID_W < $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W is too narrow to index NUM_REQ requesters");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [NUM_REQ-1:0] ACK_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t                 state_q,     state_d;
  logic [ID_W-1:0]        rr_q,        rr_d;
  logic                   dp_active_q, dp_active_d;
  logic [WIDTH-1:0]       dp_x_q,      dp_x_d;
  logic [WIDTH-1:0]       dp_y_q,      dp_y_d;
  logic [WIDTH-1:0]       res_x_q,     res_x_d;
  logic [WIDTH-1:0]       res_y_q,     res_y_d;
  logic [ID_W-1:0]        res_id_q,    res_id_d;
  logic                   res_valid_q, res_valid_d;
  logic [NUM_REQ-1:0]     ack_q,       ack_d;

  logic                   timeout_hit;

`ifdef VS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic                   res_err_q,   res_err_d;

  // The counter reads 0 in the first RUN cycle, so matching TIMEOUT-1 ends
  // the job after exactly TIMEOUT cycles of dp_active.
  assign timeout_hit = (state_q == RUN) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Unpack the operand buses so the winner can select with a plain index.
  logic [WIDTH-1:0] x_arr [NUM_REQ];
  logic [WIDTH-1:0] y_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      x_arr[i] = x_in[i*WIDTH +: WIDTH];
      y_arr[i] = y_in[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin pick: first requester at or above rr_q, wrapping at NUM_REQ.
  logic [ID_W-1:0] winner;

  always_comb begin : rr_search
    logic            found;
    logic [ID_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state and datapath-register logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    rr_d        = rr_q;
    dp_active_d = dp_active_q;
    dp_x_d      = dp_x_q;
    dp_y_d      = dp_y_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_id_d    = res_id_q;
    res_valid_d = 1'b0;
    ack_d       = '0;
`ifdef VS_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    res_err_d   = res_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        // dp_done is deliberately not looked at here: a stale or held-high
        // done must never produce a result.
        if (|req) begin
          state_d     = RUN;
          res_id_d    = winner;
          dp_x_d      = x_arr[winner];
          dp_y_d      = y_arr[winner];
          dp_active_d = 1'b1;
          rr_d        = (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
`ifdef VS_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end

      RUN: begin
        if (dp_done || timeout_hit) begin
          state_d     = RESP;
          dp_active_d = 1'b0;
          res_valid_d = 1'b1;
          ack_d       = ACK_ONE << res_id_q;
        end
        // A done arriving together with the timeout still counts as success.
        if (dp_done) begin
          res_x_d = dp_x_rot;
          res_y_d = dp_y_rot;
`ifdef VS_ARB_TIMEOUT_EN
          res_err_d = 1'b0;
`endif
        end else if (timeout_hit) begin
          res_x_d = '0;
          res_y_d = '0;
`ifdef VS_ARB_TIMEOUT_EN
          res_err_d = 1'b1;
`endif
        end
`ifdef VS_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      RESP: begin
        // Single-cycle response slot; a new grant can only follow it.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      dp_active_q <= 1'b0;
      dp_x_q      <= '0;
      dp_y_q      <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      ack_q       <= '0;
`ifdef VS_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q     <= state_d;
      rr_q        <= rr_d;
      dp_active_q <= dp_active_d;
      dp_x_q      <= dp_x_d;
      dp_y_q      <= dp_y_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      ack_q       <= ack_d;
`ifdef VS_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign dp_active = dp_active_q;
  assign dp_x      = dp_x_q;
  assign dp_y      = dp_y_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_id    = res_id_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != IDLE);
`ifdef VS_ARB_TIMEOUT_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_velocity_selector_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for velocity_selector_arbiter (NUM_REQ=4, WIDTH=16).
// The bench plays the shared datapath itself, choosing the latency and the
// rotated result of every job, and predicts grants from a round-robin model
// that searches upward from the last winner + 1.
// -----------------------------------------------------------------------------
module tb_velocity_selector_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] x_in;
  logic [NUM_REQ*WIDTH-1:0] y_in;
  logic [NUM_REQ-1:0]       ack;
  logic                     dp_active;
  logic [WIDTH-1:0]         dp_x;
  logic [WIDTH-1:0]         dp_y;
  logic                     dp_done;
  logic [WIDTH-1:0]         dp_x_rot;
  logic [WIDTH-1:0]         dp_y_rot;
  logic [WIDTH-1:0]         res_x;
  logic [WIDTH-1:0]         res_y;
  logic [ID_W-1:0]          res_id;
  logic                     res_valid;
  logic                     res_err;
  logic                     busy;

  int vectors     = 0;
  int miscompares = 0;
  int model_rr    = 0;

  velocity_selector_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .x_in      (x_in),
    .y_in      (y_in),
    .ack       (ack),
    .dp_active (dp_active),
    .dp_x      (dp_x),
    .dp_y      (dp_y),
    .dp_done   (dp_done),
    .dp_x_rot  (dp_x_rot),
    .dp_y_rot  (dp_y_rot),
    .res_x     (res_x),
    .res_y     (res_y),
    .res_id    (res_id),
    .res_valid (res_valid),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Round-robin reference: first requester at or above model_rr, wrapping.
  function automatic int model_pick(input logic [NUM_REQ-1:0] r);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(model_rr + k) % NUM_REQ]) return (model_rr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset    = 1'b1;
    req      = '0;
    dp_done  = 1'b0;
    dp_x_rot = '0;
    dp_y_rot = '0;
    tick();
    tick();
    reset    = 1'b0;
    model_rr = 0;
  endtask

  // One complete job: grant, lat RUN cycles, RESP, back to IDLE.
  // req must be nonzero and the DUT idle on entry.
  task automatic do_job(input int lat, input bit drop_in_run, input bit release_req,
                        input bit done_in_resp, output int win);
    int               exp_w;
    logic [WIDTH-1:0] ex, ey, rx, ry;
    logic [NUM_REQ-1:0] oh;
    exp_w    = model_pick(req);
    if (exp_w < 0) exp_w = 0;
    model_rr = (exp_w + 1) % NUM_REQ;
    oh       = '0;
    oh[exp_w] = 1'b1;
    ex       = x_in[exp_w*WIDTH +: WIDTH];
    ey       = y_in[exp_w*WIDTH +: WIDTH];
    win      = exp_w;

    tick();  // grant edge
    vectors++;
    if ({busy, dp_active, res_valid, ack} !== {1'b1, 1'b1, 1'b0, 4'b0000} ||
        res_id !== ID_W'(exp_w) || dp_x !== ex || dp_y !== ey) begin
      miscompares++;
      $display("FAIL grant: busy=%b act=%b vld=%b ack=%b id=%0d x=%h y=%h, want busy=1 act=1 vld=0 ack=0000 id=%0d x=%h y=%h",
               busy, dp_active, res_valid, ack, res_id, dp_x, dp_y, exp_w, ex, ey);
    end

    // Operand changes and a dropped request must not disturb the running job.
    x_in = {$urandom, $urandom};
    y_in = {$urandom, $urandom};
    if (drop_in_run) req[exp_w] = 1'b0;
    rx = WIDTH'($urandom);
    ry = WIDTH'($urandom);

    for (int c = 1; c < lat; c++) begin
      dp_done  = 1'b0;
      dp_x_rot = WIDTH'($urandom);
      dp_y_rot = WIDTH'($urandom);
      tick();
      vectors++;
      if ({busy, dp_active, res_valid, ack} !== {1'b1, 1'b1, 1'b0, 4'b0000} ||
          dp_x !== ex || dp_y !== ey) begin
        miscompares++;
        $display("FAIL run_hold: cycle=%0d busy=%b act=%b vld=%b ack=%b x=%h y=%h, want 1 1 0 0000 x=%h y=%h",
                 c, busy, dp_active, res_valid, ack, dp_x, dp_y, ex, ey);
      end
    end

    dp_done  = 1'b1;
    dp_x_rot = rx;
    dp_y_rot = ry;
    tick();  // capture edge
    vectors++;
    if ({busy, dp_active, res_valid, res_err, ack} !== {1'b1, 1'b0, 1'b1, 1'b0, oh} ||
        res_x !== rx || res_y !== ry || res_id !== ID_W'(exp_w)) begin
      miscompares++;
      $display("FAIL capture: busy=%b act=%b vld=%b err=%b ack=%b id=%0d rx=%h ry=%h, want 1 0 1 0 ack=%b id=%0d rx=%h ry=%h",
               busy, dp_active, res_valid, res_err, ack, res_id, res_x, res_y, oh, exp_w, rx, ry);
    end

    if (release_req) req[exp_w] = 1'b0;
    dp_done  = done_in_resp;  // a done seen in RESP must be ignored
    dp_x_rot = WIDTH'($urandom);
    dp_y_rot = WIDTH'($urandom);
    tick();  // RESP -> IDLE
    vectors++;
    if ({busy, dp_active, res_valid, ack} !== {1'b0, 1'b0, 1'b0, 4'b0000} ||
        res_x !== rx || res_y !== ry || res_id !== ID_W'(exp_w)) begin
      miscompares++;
      $display("FAIL resp_exit: busy=%b act=%b vld=%b ack=%b id=%0d rx=%h ry=%h, want 0 0 0 0000 id=%0d rx=%h ry=%h",
               busy, dp_active, res_valid, ack, res_id, res_x, res_y, exp_w, rx, ry);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req      = '0;
    x_in     = '0;
    y_in     = '0;
    dp_done  = 1'b0;
    dp_x_rot = '0;
    dp_y_rot = '0;
    #7;
    vectors++;
    if ({ack, dp_active, dp_x, dp_y, res_x, res_y, res_id, res_valid, res_err, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: ack=%b act=%b dpx=%h dpy=%h rx=%h ry=%h id=%0d vld=%b err=%b busy=%b, want all 0",
               ack, dp_active, dp_x, dp_y, res_x, res_y, res_id, res_valid, res_err, busy);
    end
    tick();
    reset    = 1'b0;
    model_rr = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({ack, dp_active, dp_x, dp_y, res_x, res_y, res_id, res_valid, res_err, busy} !== '0) begin
        miscompares++;
        $display("FAIL idle_quiet: cycle=%0d ack=%b act=%b vld=%b busy=%b, want all 0",
                 c, ack, dp_active, res_valid, busy);
      end
    end
  endtask

  task automatic test_single();
    int w;
    x_in = {$urandom, $urandom};
    y_in = {$urandom, $urandom};
    x_in[31:16] = 16'h0010;
    y_in[31:16] = 16'h0020;
    req = 4'b0010;
    // The job task chooses random results, so the literal values of the
    // plain single-request case are applied by hand here.
    tick();
    vectors++;
    if (dp_active !== 1'b1 || dp_x !== 16'h0010 || dp_y !== 16'h0020 || res_id !== 2'd1) begin
      miscompares++;
      $display("FAIL single_grant: act=%b x=%h y=%h id=%0d, want act=1 x=0010 y=0020 id=1",
               dp_active, dp_x, dp_y, res_id);
    end
    w = 1;
    for (int c = 1; c < 5; c++) begin
      tick();
      if (dp_active === 1'b1) w++;
    end
    dp_done  = 1'b1;
    dp_x_rot = 16'h0100;
    dp_y_rot = 16'hFF00;
    tick();
    vectors++;
    if (w !== 5 || dp_active !== 1'b0 || res_valid !== 1'b1 || ack !== 4'b0010 ||
        res_id !== 2'd1 || res_x !== 16'h0100 || res_y !== 16'hFF00) begin
      miscompares++;
      $display("FAIL single_result: active_cycles=%0d act=%b vld=%b ack=%b id=%0d rx=%h ry=%h, want 5 0 1 0010 1 0100 FF00",
               w, dp_active, res_valid, ack, res_id, res_x, res_y);
    end
    dp_done = 1'b0;
    req     = '0;
    tick();
    vectors++;
    if (res_valid !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || res_x !== 16'h0100) begin
      miscompares++;
      $display("FAIL single_resp: vld=%b ack=%b busy=%b rx=%h, want 0 0000 0 0100",
               res_valid, ack, busy, res_x);
    end
    model_rr = 2;
  endtask

  task automatic test_round_robin();
    int order [5];
    int w;
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    x_in = {$urandom, $urandom};
    y_in = {$urandom, $urandom};
    req  = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      do_job(3, 1'b0, 1'b0, 1'b0, w);
      vectors++;
      if (w !== order[j] || res_id !== ID_W'(order[j])) begin
        miscompares++;
        $display("FAIL rr_order: job=%0d served=%0d, want %0d", j, res_id, order[j]);
      end
    end
    req = '0;
  endtask

  task automatic test_stale_done();
    int w;
    req     = '0;
    dp_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (res_valid !== 1'b0 || dp_active !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
        miscompares++;
        $display("FAIL stale_done: cycle=%0d vld=%b act=%b busy=%b ack=%b, want 0 0 0 0000",
                 c, res_valid, dp_active, busy, ack);
      end
    end
    // dp_done stays high through the grant: capture on the first RUN edge.
    req = 4'b0001;
    do_job(1, 1'b0, 1'b1, 1'b0, w);
  endtask

  task automatic test_reset_mid();
    int w;
    apply_reset();
    x_in = {$urandom, $urandom};
    y_in = {$urandom, $urandom};
    req  = 4'b0100;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (dp_active !== 1'b0 || ack !== 4'b0000 || res_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: act=%b ack=%b vld=%b busy=%b, want 0 0000 0 0",
               dp_active, ack, res_valid, busy);
    end
    tick();
    reset    = 1'b0;
    model_rr = 0;
    req      = 4'b0101;
    do_job(2, 1'b0, 1'b1, 1'b0, w);
    vectors++;
    if (w !== 0 || res_id !== 2'd0) begin
      miscompares++;
      $display("FAIL post_reset_grant: served=%0d, want 0", res_id);
    end
    do_job(2, 1'b0, 1'b1, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    apply_reset();
    for (int j = 0; j < 40; j++) begin
      x_in = {$urandom, $urandom};
      y_in = {$urandom, $urandom};
      req  = req | NUM_REQ'($urandom);
      if (req == '0) req[$urandom_range(NUM_REQ-1, 0)] = 1'b1;
      do_job($urandom_range(6, 1), 1'(($urandom % 4) == 0), 1'($urandom % 2),
             1'($urandom % 2), w);
    end
    req     = '0;
    dp_done = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int act_cycles;
    int bad;
    apply_reset();
    x_in = {$urandom, $urandom};
    y_in = {$urandom, $urandom};
    req  = 4'b1000;
    tick();  // grant
`ifdef VS_ARB_TIMEOUT_EN
    act_cycles = 0;
    while (dp_active === 1'b1 && act_cycles < 200) begin
      act_cycles++;
      tick();
    end
    vectors++;
    if (act_cycles !== TIMEOUT || res_valid !== 1'b1 || res_err !== 1'b1 ||
        res_x !== '0 || res_y !== '0 || ack !== 4'b1000) begin
      miscompares++;
      $display("FAIL timeout: active_cycles=%0d vld=%b err=%b rx=%h ry=%h ack=%b, want %0d 1 1 0 0 1000",
               act_cycles, res_valid, res_err, res_x, res_y, ack, TIMEOUT);
    end
    bad = 0;
`else
    act_cycles = 0;
    bad        = 0;
    for (int c = 0; c < 200; c++) begin
      if (busy !== 1'b1 || dp_active !== 1'b1 || res_err !== 1'b0 || res_valid !== 1'b0) bad++;
      else act_cycles++;
      tick();
    end
`endif
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL no_timeout: bad_cycles=%0d, want 0 (busy held, no result, res_err 0)", bad);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stale_done();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
